// File: rtl/bft_pkg.sv
// rtl/bft_pkg.sv - shared types and helpers for the BFT T-switch scheduler
// Port encoding, packet field extraction and the T-switch routing rules.
package bft_pkg;

  // Widest packet the field helpers accept; callers widen their packet to this.
  localparam int MAX_W = 128;

  typedef enum logic [1:0] {
    PORT_L = 2'd0,
    PORT_R = 2'd1,
    PORT_U = 2'd2
  } port_e;

  function automatic int addr_width(input int num_leaves);
    return $clog2(num_leaves);
  endfunction

  function automatic logic pkt_valid(input logic [MAX_W-1:0] pkt, input int p_sz);
    logic [MAX_W-1:0] sh;
    sh = pkt >> (p_sz - 1);
    return sh[0];
  endfunction

  // The destination sits directly above the payload field.
  function automatic logic [31:0] pkt_dest(input logic [MAX_W-1:0] pkt,
                                           input int payload_sz, input int aw);
    logic [MAX_W-1:0] sh;
    sh = pkt >> payload_sz;
    return 32'(sh) & ((32'd1 << aw) - 32'd1);
  endfunction

  function automatic logic [MAX_W-1:0] pkt_payload(input logic [MAX_W-1:0] pkt,
                                                   input int payload_sz);
    return pkt & ~({MAX_W{1'b1}} << payload_sz);
  endfunction

  // Child inputs cross to the sibling when the target is local, else climb;
  // the parent input descends by the side bit. Parent never routes to itself.
  function automatic port_e route(input port_e src, input logic in_sub, input logic side);
    port_e r;
    case (src)
      PORT_L:  r = in_sub ? PORT_R : PORT_U;
      PORT_R:  r = in_sub ? PORT_L : PORT_U;
      default: r = side ? PORT_R : PORT_L;
    endcase
    return r;
  endfunction

  // The two inputs that can target a given output; second=0 is the one the
  // arbiter pointer favours out of reset.
  function automatic port_e contender(input port_e out, input logic second);
    port_e c;
    case (out)
      PORT_L:  c = second ? PORT_U : PORT_R;
      PORT_R:  c = second ? PORT_U : PORT_L;
      default: c = second ? PORT_R : PORT_L;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/t_switch_sched_if.sv
// rtl/t_switch_sched_if.sv - one flow-controlled switch port (in and out halves)
// The slave side is the switch; the master side is the neighbouring node.
interface t_switch_sched_if #(
  parameter int p_sz = 52
);
  logic [p_sz-1:0] bus_i;
  logic            rdy_o;
  logic [p_sz-1:0] bus_o;
  logic            rdy_i;

  modport master (output bus_i, output rdy_i, input bus_o, input rdy_o);
  modport slave  (input bus_i, input rdy_i, output bus_o, output rdy_o);
endinterface

// File: rtl/t_switch_in_fifo.sv
// rtl/t_switch_in_fifo.sv - 2-entry input FIFO with occupancy and ready
// Ready depends on occupancy only, so a full FIFO refuses a push while popping.
module t_switch_in_fifo #(
  parameter int w = 52
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_valid,
  input  logic         pop,
  input  logic [w-1:0] din,
  output logic [w-1:0] dout,
  output logic [1:0]   count,
  output logic         rdy
);

  logic [w-1:0] mem0_q, mem0_d;
  logic [w-1:0] mem1_q, mem1_d;
  logic [1:0]   count_q, count_d;
  logic         push;

  assign rdy   = !reset && (count_q != 2'd2);
  assign push  = push_valid && rdy;
  assign dout  = mem0_q;
  assign count = count_q;

  // mem0 is always the head; a pop shifts mem1 down before the push lands.
  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    if (pop) begin
      mem0_d = mem1_q;
    end
    if (push) begin
      if ((count_q - {1'b0, pop}) == 2'd0) begin
        mem0_d = din;
      end else begin
        mem1_d = din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
    mem0_q <= mem0_d;
    mem1_q <= mem1_d;
  end

endmodule

// File: rtl/t_switch_sched.sv
// rtl/t_switch_sched.sv - T-switch node: input FIFOs, per-output round-robin, output regs
// Packets are buffered and arbitrated, never dropped or deflected.
module t_switch_sched
  import bft_pkg::*;
#(
  parameter int num_leaves = 256,
  parameter int payload_sz = 43,
  parameter int p_sz       = 52,
  parameter int addr       = 0,
  parameter int level      = 7
) (
  input  logic            clk,
  input  logic            reset,
  t_switch_sched_if.slave l_port,
  t_switch_sched_if.slave r_port,
  t_switch_sched_if.slave u_port
);

  localparam int addr_w = addr_width(num_leaves);

  typedef logic [p_sz-1:0] pkt_t;

  pkt_t        bus_in [3];
  pkt_t        head   [3];
  pkt_t        out_q  [3];
  pkt_t        out_d  [3];
  logic [1:0]  cnt    [3];
  logic [31:0] dest_w [3];
  port_e       route_v[3];
  logic [2:0]  in_sub;
  logic [2:0]  side;
  logic [2:0]  rdy_in;
  logic [2:0]  rdy_out;
  logic [2:0]  pop;
  logic [2:0]  ptr_q, ptr_d;

  assign bus_in[0] = l_port.bus_i;
  assign bus_in[1] = r_port.bus_i;
  assign bus_in[2] = u_port.bus_i;
  assign rdy_out   = {u_port.rdy_i, r_port.rdy_i, l_port.rdy_i};

  assign l_port.rdy_o = rdy_in[0];
  assign r_port.rdy_o = rdy_in[1];
  assign u_port.rdy_o = rdy_in[2];
  assign l_port.bus_o = out_q[0];
  assign r_port.bus_o = out_q[1];
  assign u_port.bus_o = out_q[2];

  for (genvar i = 0; i < 3; i++) begin : g_in
    t_switch_in_fifo #(.w(p_sz)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_valid (bus_in[i][p_sz-1]),
      .pop        (pop[i]),
      .din        (bus_in[i]),
      .dout       (head[i]),
      .count      (cnt[i]),
      .rdy        (rdy_in[i])
    );
  end

  // Routes are decoded from each FIFO head, so only the head's route matters.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      dest_w[i]  = pkt_dest(MAX_W'(head[i]), payload_sz, addr_w);
      in_sub[i]  = (dest_w[i] >> (level + 1)) == (32'(addr) >> (level + 1));
      side[i]    = dest_w[i][level];
      route_v[i] = route(port_e'(i[1:0]), in_sub[i], side[i]);
    end
  end

  always_comb begin
    port_e ca, cb, op;
    logic  req_a, req_b, free, gnt_a, gnt_b;
    pop   = '0;
    ptr_d = ptr_q;
    for (int o = 0; o < 3; o++) begin
      op    = port_e'(o[1:0]);
      ca    = contender(op, 1'b0);
      cb    = contender(op, 1'b1);
      req_a = (cnt[ca] != 2'd0) && (route_v[ca] == op);
      req_b = (cnt[cb] != 2'd0) && (route_v[cb] == op);
      free  = !pkt_valid(MAX_W'(out_q[o]), p_sz) || rdy_out[o];
      gnt_a = free && req_a && (!req_b || !ptr_q[o]);
      gnt_b = free && req_b && (!req_a || ptr_q[o]);
      // A free stage either reloads or drains to all-zeros.
      out_d[o] = free ? '0 : out_q[o];
      if (gnt_a) begin
        out_d[o] = head[ca];
        pop[ca]  = 1'b1;
      end
      if (gnt_b) begin
        out_d[o] = head[cb];
        pop[cb]  = 1'b1;
      end
      // After a contested grant the loser becomes the favoured contender.
      if (free && req_a && req_b) begin
        ptr_d[o] = gnt_a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 3'b000;
      for (int o = 0; o < 3; o++) begin
        out_q[o] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int o = 0; o < 3; o++) begin
        out_q[o] <= out_d[o];
      end
    end
  end

endmodule

// File: tb/tb_t_switch_sched.sv
// tb/tb_t_switch_sched.sv - directed scoreboard bench for t_switch_sched
// Subtree is leaves 8..11 (addr=8, level=1); payload[42:40] tags the source port.
module tb_t_switch_sched;

  localparam int P_SZ = 52;

  typedef struct {
    int              src;
    int              dst;
    logic [P_SZ-1:0] pkt;
  } sb_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   cyc;

  sb_t             sb[$];
  logic [P_SZ-1:0] txl[$];
  logic [P_SZ-1:0] txr[$];
  logic [P_SZ-1:0] txu[$];
  logic [P_SZ-1:0] ulog[$];
  int              ulog_cyc[$];

  t_switch_sched_if #(.p_sz(P_SZ)) l_if ();
  t_switch_sched_if #(.p_sz(P_SZ)) r_if ();
  t_switch_sched_if #(.p_sz(P_SZ)) u_if ();

  t_switch_sched #(
    .num_leaves (256),
    .payload_sz (43),
    .p_sz       (P_SZ),
    .addr       (8),
    .level      (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .l_port (l_if),
    .r_port (r_if),
    .u_port (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [P_SZ-1:0] mk(input int src, input int dest, input int val);
    return {1'b1, 8'(dest), 3'(src), 40'(val)};
  endfunction

  function automatic int tb_route(input int src, input int dest);
    bit in_sub;
    bit side;
    in_sub = (dest >> 2) == (8 >> 2);
    side   = ((dest >> 1) & 1) == 1;
    if (src == 0) return in_sub ? 1 : 2;
    if (src == 1) return in_sub ? 0 : 2;
    return side ? 1 : 0;
  endfunction

  function automatic logic [P_SZ-1:0] obus(input int o);
    if (o == 0) return l_if.bus_o;
    if (o == 1) return r_if.bus_o;
    return u_if.bus_o;
  endfunction

  function automatic logic ordy(input int o);
    if (o == 0) return l_if.rdy_i;
    if (o == 1) return r_if.rdy_i;
    return u_if.rdy_i;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input int src, input logic [P_SZ-1:0] pkt);
    sb_t e;
    e.src = src;
    e.dst = tb_route(src, int'(pkt[50:43]));
    e.pkt = pkt;
    sb.push_back(e);
  endtask

  task automatic monitor(input int o, input logic [P_SZ-1:0] pkt);
    int src;
    int idx;
    src = int'(pkt[42:40]);
    idx = -1;
    for (int k = 0; k < sb.size(); k++) begin
      if (idx < 0 && sb[k].src == src && sb[k].dst == o) idx = k;
    end
    chk($sformatf("sb_found_out%0d", o), 64'(idx >= 0), 64'(1));
    if (idx >= 0) begin
      chk($sformatf("sb_pkt_out%0d", o), 64'(pkt), 64'(sb[idx].pkt));
      sb.delete(idx);
    end
    if (o == 2) begin
      ulog.push_back(pkt);
      ulog_cyc.push_back(cyc);
    end
  endtask

  task automatic drive();
    l_if.bus_i = (txl.size() > 0) ? txl[0] : '0;
    r_if.bus_i = (txr.size() > 0) ? txr[0] : '0;
    u_if.bus_i = (txu.size() > 0) ? txu[0] : '0;
  endtask

  // One clock: observe outputs and acceptances mid-cycle, then advance.
  task automatic tick();
    logic [P_SZ-1:0] ob;
    drive();
    @(negedge clk);
    for (int o = 0; o < 3; o++) begin
      ob = obus(o);
      if (ob[P_SZ-1] && ordy(o)) monitor(o, ob);
    end
    if (l_if.bus_i[P_SZ-1] && l_if.rdy_o) begin sb_push(0, txl[0]); void'(txl.pop_front()); end
    if (r_if.bus_i[P_SZ-1] && r_if.rdy_o) begin sb_push(1, txr[0]); void'(txr.pop_front()); end
    if (u_if.bus_i[P_SZ-1] && u_if.rdy_o) begin sb_push(2, txu[0]); void'(txu.pop_front()); end
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    reset = 1'b1;
    l_if.rdy_i = 1'b1;
    r_if.rdy_i = 1'b1;
    u_if.rdy_i = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_l_rdy", 64'(l_if.rdy_o), 64'(0));
    chk("rst_r_rdy", 64'(r_if.rdy_o), 64'(0));
    chk("rst_u_rdy", 64'(u_if.rdy_o), 64'(0));
    chk("rst_l_bus", 64'(l_if.bus_o), 64'(0));
    chk("rst_r_bus", 64'(r_if.bus_o), 64'(0));
    chk("rst_u_bus", 64'(u_if.bus_o), 64'(0));
    reset = 1'b0;
    #1;
    chk("post_rst_l_rdy", 64'(l_if.rdy_o), 64'(1));
    chk("post_rst_u_rdy", 64'(u_if.rdy_o), 64'(1));

    // l -> r, two-cycle latency
    txl.push_back(mk(0, 10, 1));
    tick();
    chk("t1_r_early", 64'(r_if.bus_o), 64'(0));
    tick();
    chk("t1_r_bus", 64'(r_if.bus_o), 64'(mk(0, 10, 1)));
    chk("t1_l_idle", 64'(l_if.bus_o), 64'(0));
    chk("t1_u_idle", 64'(u_if.bus_o), 64'(0));
    tick();

    // l -> u
    txl.push_back(mk(0, 'h40, 2));
    tick();
    tick();
    chk("t2_u_bus", 64'(u_if.bus_o), 64'(mk(0, 'h40, 2)));
    tick();

    // u -> l then u -> r on consecutive cycles
    txu.push_back(mk(2, 9, 3));
    txu.push_back(mk(2, 11, 4));
    tick();
    tick();
    chk("t3_l_bus", 64'(l_if.bus_o), 64'(mk(2, 9, 3)));
    chk("t3_r_idle", 64'(r_if.bus_o), 64'(0));
    tick();
    chk("t3_r_bus", 64'(r_if.bus_o), 64'(mk(2, 11, 4)));
    chk("t3_l_drained", 64'(l_if.bus_o), 64'(0));
    tick();

    // Three distinct routes forward concurrently
    txl.push_back(mk(0, 'h40, 5));
    txr.push_back(mk(1, 8, 6));
    txu.push_back(mk(2, 10, 7));
    tick();
    tick();
    chk("t4_u_bus", 64'(u_if.bus_o), 64'(mk(0, 'h40, 5)));
    chk("t4_l_bus", 64'(l_if.bus_o), 64'(mk(1, 8, 6)));
    chk("t4_r_bus", 64'(r_if.bus_o), 64'(mk(2, 10, 7)));
    tick();

    // Contention for u: strict alternation starting with l
    ulog.delete();
    ulog_cyc.delete();
    for (int k = 0; k < 4; k++) begin
      txl.push_back(mk(0, 'h40, k));
      txr.push_back(mk(1, 'h40, k));
    end
    repeat (12) tick();
    chk("t5_u_count", 64'(ulog.size()), 64'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < ulog.size())
        chk($sformatf("t5_u_order%0d", i), 64'(ulog[i]), 64'(mk(i % 2, 'h40, i / 2)));
    end

    // Backpressure on u
    ulog.delete();
    ulog_cyc.delete();
    u_if.rdy_i = 1'b0;
    for (int k = 0; k < 4; k++) txl.push_back(mk(0, 'h40, 'hA + k));
    repeat (5) tick();
    chk("t6_u_hold", 64'(u_if.bus_o), 64'(mk(0, 'h40, 'hA)));
    chk("t6_l_rdy_low", 64'(l_if.rdy_o), 64'(0));
    chk("t6_d_pending", 64'(txl.size()), 64'(1));
    chk("t6_none_out", 64'(ulog.size()), 64'(0));
    u_if.rdy_i = 1'b1;
    repeat (6) tick();
    chk("t6_u_count", 64'(ulog.size()), 64'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < ulog.size())
        chk($sformatf("t6_u_order%0d", i), 64'(ulog[i]), 64'(mk(0, 'h40, 'hA + i)));
    end
    if (ulog_cyc.size() >= 3) begin
      chk("t6_ab_gap", 64'(ulog_cyc[1] - ulog_cyc[0]), 64'(1));
      chk("t6_bc_gap", 64'(ulog_cyc[2] - ulog_cyc[1]), 64'(1));
    end

    // Mid-operation reset with every FIFO full
    l_if.rdy_i = 1'b0;
    r_if.rdy_i = 1'b0;
    u_if.rdy_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      txl.push_back(mk(0, 'h40, 'h20 + k));
      txr.push_back(mk(1, 'h40, 'h30 + k));
    end
    for (int k = 0; k < 3; k++) txu.push_back(mk(2, 9, 'h40 + k));
    repeat (6) tick();
    chk("t7_l_full", 64'(l_if.rdy_o), 64'(0));
    chk("t7_r_full", 64'(r_if.rdy_o), 64'(0));
    chk("t7_u_full", 64'(u_if.rdy_o), 64'(0));
    txl.delete();
    txr.delete();
    txu.delete();
    sb.delete();
    drive();
    reset = 1'b1;
    #1;
    chk("t7_rst_l_rdy", 64'(l_if.rdy_o), 64'(0));
    chk("t7_rst_u_rdy", 64'(u_if.rdy_o), 64'(0));
    @(posedge clk);
    #1;
    chk("t7_rst_l_bus", 64'(l_if.bus_o), 64'(0));
    chk("t7_rst_r_bus", 64'(r_if.bus_o), 64'(0));
    chk("t7_rst_u_bus", 64'(u_if.bus_o), 64'(0));
    reset = 1'b0;
    #1;
    chk("t7_rel_l_rdy", 64'(l_if.rdy_o), 64'(1));
    chk("t7_rel_r_rdy", 64'(r_if.rdy_o), 64'(1));
    chk("t7_rel_u_rdy", 64'(u_if.rdy_o), 64'(1));
    l_if.rdy_i = 1'b1;
    r_if.rdy_i = 1'b1;
    u_if.rdy_i = 1'b1;
    repeat (8) tick();
    chk("t7_l_quiet", 64'(l_if.bus_o), 64'(0));
    chk("t7_u_quiet", 64'(u_if.bus_o), 64'(0));

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
